// File: rtl/product_accumulator_pkg.sv
// Shared types and helpers for the product accumulator.
package product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Number of result bytes sent for a given accumulator width.
  function automatic int acc_bytes(input int acc_w);
    return acc_w / 8;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input stream and result byte output stream.
interface product_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/product_accumulator_serializer.sv
// Returns the accumulator LSB first, one byte per out_ready handshake.
module acc_byte_serializer
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [ACC_W-1:0] acc,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             last_hs,
  output logic             done
);

  localparam int N_BYTES = acc_bytes(ACC_W);
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  logic [IDX_W-1:0] idx;
  logic             valid_q;
  logic             done_q;

  // Handshake on the final byte; the FSM uses it to return to IDLE.
  assign last_hs = valid_q & out_ready & (idx == LAST_IDX);

  // Byte index, valid flag and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (clear) begin
      idx     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last_hs;
      if (load) begin
        valid_q <= 1'b1;
        idx     <= '0;
      end else if (valid_q && out_ready) begin
        if (idx == LAST_IDX) begin
          valid_q <= 1'b0;
          idx     <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Byte select from registered state only; zero when nothing is offered.
  always_comb begin
    out_data = 8'h00;
    if (valid_q) out_data = 8'(acc >> {idx, 3'b000});
  end

  assign out_valid = valid_q;
  assign done      = done_q;

endmodule

// File: rtl/product_accumulator.sv
// Multiply-accumulate back end: sums a batch of 8-bit products, then
// streams the wide sum out a byte at a time.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 start,
  input  logic [CNT_W-1:0]     batch_len,
  product_accumulator_if.slave bus,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 busy,
  output logic                 ovf,
  output logic                 done
);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_m1;
  logic             ovf_q;
  logic             accept;
  logic             last_prod;
  logic             load;
  logic             last_hs;

  // len_q of 0 wraps to all-ones here, giving a full 2^CNT_W batch.
  assign len_m1    = len_q - 1'b1;
  assign accept    = bus.in_valid & (state == ACCUM);
  assign last_prod = accept & (cnt == len_m1);
  assign sum       = {1'b0, acc} + (ACC_W + 1)'(bus.in_data);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode and serializer load pulse; clear overrides everything.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = ACCUM;
      ACCUM: if (last_prod) begin
               state_nx = SEND;
               load     = 1'b1;
             end
      SEND:  if (last_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) begin
      state_nx = IDLE;
      load     = 1'b0;
    end
  end

  // Accumulator, product counter, batch length and sticky carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (state == IDLE && start) begin
      len_q <= batch_len;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      acc   <= sum[ACC_W-1:0];
      ovf_q <= ovf_q | sum[ACC_W];
      cnt   <= cnt + 1'b1;
    end
  end

  acc_byte_serializer #(.ACC_W(ACC_W)) u_ser (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .load      (load),
    .acc       (acc),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .last_hs   (last_hs),
    .done      (done)
  );

  assign bus.in_ready = (state == ACCUM);
  assign busy         = (state != IDLE);
  assign acc_out      = acc;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 16-bit and an 8-bit accumulator with the same stimulus and
// compares both against a plain-arithmetic batch model.
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       start;
  logic [3:0] batch_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [15:0] acc16;
  logic [7:0]  acc8;
  logic        busy16, ovf16, done16;
  logic        busy8, ovf8, done8;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] prod_q[$];

  always #5 clk = ~clk;

  product_accumulator_if if16 ();
  product_accumulator_if if8 ();

  assign if16.in_valid  = in_valid;
  assign if16.in_data   = in_data;
  assign if16.out_ready = out_ready;
  assign if8.in_valid   = in_valid;
  assign if8.in_data    = in_data;
  assign if8.out_ready  = out_ready;

  product_accumulator #(.ACC_W(16), .CNT_W(4)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .batch_len(batch_len),
    .bus(if16.slave), .acc_out(acc16), .busy(busy16), .ovf(ovf16), .done(done16)
  );

  product_accumulator #(.ACC_W(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .start(start), .batch_len(batch_len),
    .bus(if8.slave), .acc_out(acc8), .busy(busy8), .ovf(ovf8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy16"}, busy16, 0);
    check({tag, "_busy8"}, busy8, 0);
    check({tag, "_in_ready16"}, if16.in_ready, 0);
    check({tag, "_out_valid16"}, if16.out_valid, 0);
    check({tag, "_out_valid8"}, if8.out_valid, 0);
    check({tag, "_out_data16"}, if16.out_data, 0);
    check({tag, "_acc16"}, acc16, 0);
    check({tag, "_acc8"}, acc8, 0);
    check({tag, "_ovf8"}, ovf8, 0);
    check({tag, "_done16"}, done16, 0);
  endtask

  // One batch using the products in prod_q; expected result is the plain sum.
  task automatic run_batch(input logic [3:0] len, input int bubble_pct, input int hold,
                           input int bp_pct, input bit start_in_send);
    int n;
    int total;
    int i;
    int budget;
    int cyc;
    int idx16;
    int idx8;
    bit got_it, hs16, hs8;
    logic [15:0] e16;
    logic [7:0]  e8;
    n = (len == 4'd0) ? 16 : int'(len);
    total = 0; i = 0; budget = 0; cyc = 0; idx16 = 0; idx8 = 0;

    start = 1'b1; batch_len = len;
    step();
    start = 1'b0; batch_len = 4'($urandom);
    check("start_busy16", busy16, 1);
    check("start_busy8", busy8, 1);
    check("start_acc16", acc16, 0);
    check("start_ovf8", ovf8, 0);
    check("start_in_ready8", if8.in_ready, 1);

    while (i < n && budget < 300) begin
      in_valid = ($urandom_range(99) >= bubble_pct);
      in_data  = in_valid ? prod_q[i] : 8'($urandom);
      got_it   = in_valid;
      step();
      budget++;
      if (got_it) begin
        total += int'(prod_q[i]);
        i++;
      end
      check("accum_acc16", acc16, total % 65536);
      check("accum_acc8", acc8, total % 256);
      if (i < n) check("accum_in_ready16", if16.in_ready, 1);
    end
    in_valid = 1'b0;
    if (i < n) check("accum_timeout", i, n);

    e16 = 16'(total);
    e8  = 8'(total);
    check("send_in_ready16", if16.in_ready, 0);
    check("send_out_valid16", if16.out_valid, 1);
    check("send_out_valid8", if8.out_valid, 1);
    check("send_first16", if16.out_data, e16[7:0]);
    check("send_first8", if8.out_data, e8);

    while ((idx16 < 2 || idx8 < 1) && cyc < 300) begin
      out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) >= bp_pct);
      start = start_in_send && (idx8 == 0) && ($urandom_range(1) == 1);
      hs16 = if16.out_valid & out_ready;
      hs8  = if8.out_valid & out_ready;
      step();
      cyc++;
      start = 1'b0;
      if (hs16) idx16++;
      if (hs8) idx8++;
      check("done16", done16, hs16 && idx16 == 2);
      check("done8", done8, hs8 && idx8 == 1);
      check("out_valid16", if16.out_valid, idx16 < 2);
      check("busy16", busy16, idx16 < 2);
      check("busy8", busy8, idx8 < 1);
      if (idx16 < 2) check("out_data16", if16.out_data, (e16 >> (8 * idx16)) & 16'h00ff);
      if (idx8 < 1) check("out_data8", if8.out_data, e8);
    end
    out_ready = 1'b0;
    if (idx16 < 2) check("send_timeout16", idx16, 2);
    if (idx8 < 1) check("send_timeout8", idx8, 1);

    step();
    check("after_done16", done16, 0);
    check("after_done8", done8, 0);
    check("after_busy16", busy16, 0);
    check("after_out_valid16", if16.out_valid, 0);
    check("after_out_data16", if16.out_data, 0);
    check("hold_acc16", acc16, e16);
    check("hold_acc8", acc8, e8);
    check("hold_ovf16", ovf16, total >= 65536);
    check("hold_ovf8", ovf8, total >= 256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; batch_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check("reset_idle_busy16", busy16, 0);

    // Basic batch.
    prod_q = '{8'h0F, 8'hE1, 8'h30};
    run_batch(4'd3, 0, 0, 0, 1'b0);
    check("basic_acc16", acc16, 16'h0120);
    check("basic_ovf16", ovf16, 0);

    // Back-pressure with input bubbles.
    run_batch(4'd3, 40, 3, 0, 1'b0);
    check("bp_acc16", acc16, 16'h0120);

    // Overflow in the 8-bit instance.
    prod_q = '{8'hC8, 8'h64};
    run_batch(4'd2, 0, 0, 0, 1'b0);
    check("ovf_acc8", acc8, 8'h2C);
    check("ovf_flag8", ovf8, 1);

    // Full-length batch, start pulses during SEND.
    prod_q.delete();
    for (int k = 0; k < 16; k++) prod_q.push_back(8'hE1);
    run_batch(4'd0, 0, 1, 30, 1'b1);
    check("len0_acc16", acc16, 16'h0E10);

    // Clear mid-ACCUM.
    start = 1'b1; batch_len = 4'd3;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    step();
    check("clr_pre_acc16", acc16, 16'h0055);
    clear = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0;
    check_all_zero("clear");
    for (int k = 0; k < 3; k++) begin
      step();
      check("clear_no_out_valid", if16.out_valid, 0);
    end

    // Clear and start together.
    clear = 1'b1; start = 1'b1; batch_len = 4'd2;
    step();
    clear = 1'b0; start = 1'b0;
    check("clear_start_busy16", busy16, 0);

    // Randomized batches.
    for (int b = 0; b < 20; b++) begin
      logic [3:0] len;
      int n;
      len = 4'($urandom);
      n = (len == 4'd0) ? 16 : int'(len);
      prod_q.delete();
      for (int k = 0; k < n; k++) prod_q.push_back(8'($urandom_range(255)));
      run_batch(len, 30, $urandom_range(2), 40, 1'($urandom_range(1)));
    end

    // Reset asserted mid-cycle while SEND is in progress.
    start = 1'b1; batch_len = 4'd2;
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 8'hC8;
    step();
    in_data = 8'h64;
    step();
    in_valid = 1'b0;
    check("rst_pre_out_valid16", if16.out_valid, 1);
    check("rst_pre_ovf8", ovf8, 1);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rst_post_busy16", busy16, 0);
    check("rst_post_out_valid16", if16.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
